// File: rtl/mul_pkg.sv
// Shared types and helpers for the pipelined multiplier unit.
// Operation codes, select widths and the one-mux operand helper.
package mul_pkg;

    localparam int OP_W  = 3;
    localparam int SEL_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MUL  = 3'd0,
        OP_MULH = 3'd1,
        OP_MUX3 = 3'd2,
        OP_ADD  = 3'd3,
        OP_MAC  = 3'd4,
        OP_CLR  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_t;

    // Deselected operands become the multiplicative identity.
    function automatic logic [31:0] sel_operand(input logic [31:0] x, input logic en);
        return en ? x : 32'd1;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One pipeline slot: valid bit plus payload, moving only when the pipe advances.
module mul_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (en) begin
            valid <= in_valid;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/mult.sv
// Signed W-bit multiplier returning the low W bits of x*y.
// A zero operand forces an exact zero so unknowns never leak through.
module mult #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    output logic signed [W-1:0] p
);

    assign p = (x == '0 || y == '0) ? '0 : x * y;

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined multiply/MAC unit with valid/ready handshake and a global stall.
// Products form ahead of the LAT-1 payload stages; the output stage picks the op result.
module mul_pipe_unit
    import mul_pkg::*;
#(
    parameter int N   = 8,
    parameter int LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  op_t                  op,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    input  logic [N-1:0]         c,
    input  logic [SEL_W-1:0]     sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         result,
    output logic [N-1:0]         acc
);

    localparam int W2 = 2 * N;

    typedef struct packed {
        op_t           op;
        logic [W2-1:0] prod;
        logic [N-1:0]  prod3;
        logic [N-1:0]  sum;
    } pay_t;

    localparam int PW = $bits(pay_t);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Full-width signed a*b feeds both MUL/MAC (low half) and MULH (high half).
    logic signed [W2-1:0] a_x, b_x, prod_ab;
    assign a_x = W2'($signed(a));
    assign b_x = W2'($signed(b));

    mult #(.W(W2)) u_mult_ab (.x(a_x), .y(b_x), .p(prod_ab));

    // MUX3 only needs the product mod 2^N, so an N-bit chain is exact.
    logic signed [N-1:0] m_a, m_b, m_c, p_ab_sel, p_abc_sel;
    assign m_a = N'(sel_operand(32'($signed(a)), sel[0]));
    assign m_b = N'(sel_operand(32'($signed(b)), sel[1]));
    assign m_c = N'(sel_operand(32'($signed(c)), sel[2]));

    mult #(.W(N)) u_mult_s1 (.x(m_a),      .y(m_b), .p(p_ab_sel));
    mult #(.W(N)) u_mult_s2 (.x(p_ab_sel), .y(m_c), .p(p_abc_sel));

    pay_t pay_in;
    always_comb begin
        pay_in.op    = op;
        pay_in.prod  = prod_ab;
        pay_in.prod3 = (sel == '0) ? '0 : p_abc_sel;
        pay_in.sum   = a + b;
    end

    logic vld [LAT];
    pay_t dat [LAT];

    assign vld[0] = in_valid;
    assign dat[0] = pay_in;

    for (genvar i = 1; i < LAT; i++) begin : g_stage
        logic [PW-1:0] q;
        mul_pipe_stage #(.W(PW)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .en       (advance),
            .in_valid (vld[i-1]),
            .in_data  (dat[i-1]),
            .valid    (vld[i]),
            .data     (q)
        );
        assign dat[i] = pay_t'(q);
    end

    pay_t         fin;
    logic         fin_vld;
    logic [N-1:0] res_next, acc_next;

    assign fin     = dat[LAT-1];
    assign fin_vld = vld[LAT-1];

    always_comb begin
        res_next = '0;
        acc_next = acc;
        case (fin.op)
            OP_MUL:  res_next = fin.prod[N-1:0];
            OP_MULH: res_next = fin.prod[W2-1:N];
            OP_MUX3: res_next = fin.prod3;
            OP_ADD:  res_next = fin.sum;
            OP_MAC: begin
                res_next = acc + fin.prod[N-1:0];
                acc_next = res_next;
            end
            OP_CLR:  acc_next = '0;
            default: res_next = '0;
        endcase
    end

    // acc only moves when a valid request lands, so a stall cannot re-apply a MAC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            acc       <= '0;
        end else if (advance) begin
            out_valid <= fin_vld;
            if (fin_vld) begin
                result <= res_next;
                acc    <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Bench for mul_pipe_unit: vector table, hand sequences and a randomized scoreboard.
module tb_mul_pipe_unit;
    import mul_pkg::*;

    localparam int N   = 8;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    op_t          op = OP_MUL;
    logic [N-1:0] a = '0, b = '0, c = '0;
    logic [2:0]   sel = '0;

    logic         in_ready, out_valid;
    logic [N-1:0] result, acc;
    logic         in_ready1, out_valid1, in_ready4, out_valid4;
    logic [N-1:0] result1, acc1, result4, acc4;

    always #5 clk = ~clk;

    mul_pipe_unit #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .c(c), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .acc(acc)
    );

    mul_pipe_unit #(.N(N), .LAT(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .c(c), .sel(sel),
        .out_valid(out_valid1), .out_ready(1'b1), .result(result1), .acc(acc1)
    );

    mul_pipe_unit #(.N(N), .LAT(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .op(op), .a(a), .b(b), .c(c), .sel(sel),
        .out_valid(out_valid4), .out_ready(1'b1), .result(result4), .acc(acc4)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the signed operands.
    typedef struct {
        logic [N-1:0] res;
        logic [N-1:0] acc;
    } exp_t;

    function automatic exp_t model(input op_t o, input logic [N-1:0] xa, input logic [N-1:0] xb,
                                   input logic [N-1:0] xc, input logic [2:0] s,
                                   input logic [N-1:0] cur_acc);
        exp_t   e;
        longint sa, sb, sc, r;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        sc = longint'($signed(xc));
        r = 0;
        e.acc = cur_acc;
        case (o)
            OP_MUL:  r = sa * sb;
            OP_MULH: r = (sa * sb) >>> N;
            OP_MUX3: r = (s == 3'b000) ? 0 :
                         (s[0] ? sa : 1) * (s[1] ? sb : 1) * (s[2] ? sc : 1);
            OP_ADD:  r = sa + sb;
            OP_MAC: begin
                r = longint'(cur_acc) + sa * sb;
                e.acc = N'(r);
            end
            OP_CLR:  e.acc = '0;
            default: r = 0;
        endcase
        e.res = N'(r);
        return e;
    endfunction

    exp_t         sb_q[$];
    exp_t         e_mon;
    logic [N-1:0] m_acc = '0;
    bit           prev_stall = 1'b0;
    logic [N-1:0] prev_res = '0;

    // Scoreboard monitor on the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            m_acc = '0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_result", result, prev_res);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%0h required=none", result);
                end else begin
                    e_mon = sb_q.pop_front();
                    chk("sb_result", result, e_mon.res);
                    chk("sb_acc", acc, e_mon.acc);
                end
            end
            if (in_valid && in_ready) begin
                e_mon = model(op, a, b, c, sel, m_acc);
                m_acc = e_mon.acc;
                sb_q.push_back(e_mon);
            end
            prev_stall = out_valid && !out_ready;
            prev_res = result;
        end
    end

    typedef struct {
        string        name;
        op_t          o;
        logic [N-1:0] va, vb, vc;
        logic [2:0]   s;
        logic [N-1:0] r, ac;
    } vec_t;

    vec_t tbl[11];

    // Issue a single request into an empty pipe and check latency and value.
    task automatic issue_one(input string name, input op_t o, input logic [N-1:0] xa,
                             input logic [N-1:0] xb, input logic [N-1:0] xc, input logic [2:0] s,
                             input logic [N-1:0] er, input logic [N-1:0] ea);
        int cyc = 0;
        op = o; a = xa; b = xb; c = xc; sel = s;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, cyc, LAT - 1);
        chk({name, "_result"}, result, er);
        chk({name, "_acc"}, acc, ea);
        @(posedge clk); #1;
        chk({name, "_valid_drop"}, out_valid, 0);
    endtask

    function automatic logic [N-1:0] rnd();
        return ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
    endfunction

    initial begin
        int got, cyc, idx;
        bit acc_ok, dlv;
        op_t          bo[3];
        logic [N-1:0] ba[3];
        logic [N-1:0] bexp[3];

        tbl[0]  = '{"mul_neg",   OP_MUL,  8'hFD, 8'h05, 8'h00, 3'b000, 8'hF1, 8'h00};
        tbl[1]  = '{"mul_zero",  OP_MUL,  8'h00, 8'h55, 8'h00, 3'b000, 8'h00, 8'h00};
        tbl[2]  = '{"mulh_pos",  OP_MULH, 8'h64, 8'h64, 8'h00, 3'b000, 8'h27, 8'h00};
        tbl[3]  = '{"mulh_min",  OP_MULH, 8'h80, 8'h80, 8'h00, 3'b000, 8'h40, 8'h00};
        tbl[4]  = '{"add_wrap",  OP_ADD,  8'h7F, 8'h01, 8'h00, 3'b000, 8'h80, 8'h00};
        tbl[5]  = '{"mux3_101",  OP_MUX3, 8'h02, 8'h07, 8'hFC, 3'b101, 8'hF8, 8'h00};
        tbl[6]  = '{"mux3_010",  OP_MUX3, 8'h02, 8'h07, 8'hFC, 3'b010, 8'h07, 8'h00};
        tbl[7]  = '{"mux3_000",  OP_MUX3, 8'h02, 8'h07, 8'hFC, 3'b000, 8'h00, 8'h00};
        tbl[8]  = '{"mux3_111",  OP_MUX3, 8'h02, 8'h07, 8'hFC, 3'b111, 8'hC8, 8'h00};
        tbl[9]  = '{"op6",       OP_RSV6, 8'h03, 8'h03, 8'h03, 3'b111, 8'h00, 8'h00};
        tbl[10] = '{"op7",       OP_RSV7, 8'h09, 8'h09, 8'h09, 3'b011, 8'h00, 8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_acc", acc, 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Latency of the LAT=1 and LAT=4 instances
        op = OP_MUL; a = 8'hFD; b = 8'h05; c = '0; sel = '0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat1_valid", out_valid1, 1);
        chk("lat1_result", result1, 8'hF1);
        chk("lat4_early0", out_valid4, 0);
        for (int i = 1; i < 3; i++) begin
            @(posedge clk); #1;
            chk("lat4_early", out_valid4, 0);
        end
        @(posedge clk); #1;
        chk("lat4_valid", out_valid4, 1);
        chk("lat4_result", result4, 8'hF1);
        repeat (2) @(posedge clk);
        #1;

        // Single-op vector table
        for (int i = 0; i < 11; i++)
            issue_one(tbl[i].name, tbl[i].o, tbl[i].va, tbl[i].vb, tbl[i].vc, tbl[i].s,
                      tbl[i].r, tbl[i].ac);

        // Back-to-back MACs
        op = OP_MAC; a = 8'd3; b = 8'd4; sel = '0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        a = 8'd5; b = 8'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 0;
        cyc = 0;
        while (got < 2 && cyc < 20) begin
            if (out_valid) begin
                chk("mac_result", result, (got == 0) ? 12 : 42);
                chk("mac_acc", acc, (got == 0) ? 12 : 42);
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("mac_count", got, 2);
        issue_one("clr", OP_CLR, 8'h11, 8'h22, 8'h33, 3'b111, 8'h00, 8'h00);

        // Backpressure with a full pipe
        bo = '{OP_MAC, OP_MAC, OP_MUL};
        ba = '{8'd2, 8'd3, 8'd4};
        bexp = '{8'd4, 8'd13, 8'd16};
        idx = 0;
        got = 0;
        cyc = 0;
        while ((idx < 3 || got < 3) && cyc < 40) begin
            out_ready = (cyc >= 6);
            if (idx < 3) begin
                in_valid = 1'b1;
                op = bo[idx];
                a = ba[idx];
                b = ba[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 5) begin
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_result_held", result, 8'd4);
                chk("bp_acc", acc, 8'd4);
                chk("bp_accepted", idx, 2);
            end
            acc_ok = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (dlv) begin
                chk("bp_order", result, bexp[got]);
                got++;
            end
            @(posedge clk); #1;
            if (acc_ok) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", got, 3);
        chk("bp_final_acc", acc, 8'd13);

        issue_one("clr2", OP_CLR, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00);
        issue_one("mac67", OP_MAC, 8'd6, 8'd7, 8'h00, 3'b000, 8'h2A, 8'h2A);

        // Asynchronous reset with two requests in flight
        op = OP_MUL; a = 8'd1; b = 8'd1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        a = 8'd2; b = 8'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_acc", acc, 8'h2A);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_acc", acc, 0);
        chk("async_rst_result", result, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("no_stale", out_valid, 0);
        end

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 500; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            op = op_t'($urandom_range(0, 7));
            a = rnd();
            b = rnd();
            c = rnd();
            sel = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        chk("drain_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
